// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size encodings, FSM states and the request error check for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        LD_WAIT,
        ST_MERGE,
        RESP
    } state_e;

    function automatic logic access_err(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic        check_range,
        input logic [31:0] mem_words
    );
        return (size == SZ_RSVD)
            || (size == SZ_HALF && addr[0])
            || (size == SZ_WORD && addr[1:0] != 2'b00)
            || (check_range && {2'b00, addr[31:2]} >= mem_words);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extraction with sign/zero extension and sub-word store merge
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  b;
    logic [15:0] h;

    // pick the addressed lane for loads and splice the new lane into the old word for stores
    always_comb begin
        b          = word[{lane, 3'b000} +: 8];
        h          = lane[1] ? word[31:16] : word[15:0];
        load_val   = size == SZ_BYTE ? {{24{sgn & b[7]}}, b}
                   : size == SZ_HALF ? {{16{sgn & h[15]}}, h} : word;
        store_word = word;
        if (size == SZ_BYTE)
            store_word[{lane, 3'b000} +: 8] = wdata[7:0];
        else if (size == SZ_HALF)
            store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        else
            store_word = wdata;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences byte/half/word loads and stores onto a word-only memory with registered reads
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS   = 256,
    parameter bit CHECK_RANGE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        MemRead,
    output logic        MemWrite
);

    state_e      state, next;
    logic [1:0]  q_size;
    logic        q_sgn;
    logic [31:0] q_addr, q_wdata;
    logic [31:0] load_val, store_word;
    logic        accept, err;

    assign accept     = req_valid & req_ready;
    assign err        = access_err(req_size, req_addr, CHECK_RANGE, 32'(MEM_WORDS));
    assign resp_valid = state == RESP;

    lsu_lane_align u_align (
        .word       (mem_read_data),
        .lane       (q_addr[1:0]),
        .size       (q_size),
        .sgn        (q_sgn),
        .wdata      (q_wdata),
        .load_val   (load_val),
        .store_word (store_word)
    );

    // next state and memory strobes; IDLE commands come straight from the request so the memory samples them on the accept edge
    always_comb begin
        next           = state;
        req_ready      = rst_n && state == IDLE;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        mem_addr       = {q_addr[31:2], 2'b00};
        mem_write_data = '0;
        case (state)
            IDLE: begin
                mem_addr = {req_addr[31:2], 2'b00};
                if (accept) begin
                    if (err) begin
                        next = RESP;
                    end else if (!req_write) begin
                        MemRead = 1'b1;
                        next    = LD_WAIT;
                    end else if (req_size == SZ_WORD) begin
                        MemWrite       = 1'b1;
                        mem_write_data = req_wdata;
                        next           = RESP;
                    end else begin
                        MemRead = 1'b1;
                        next    = ST_MERGE;
                    end
                end
            end
            LD_WAIT: next = RESP;
            ST_MERGE: begin
                MemWrite       = 1'b1;
                mem_write_data = store_word;
                next           = RESP;
            end
            default: next = IDLE;
        endcase
        if (!rst_n)
            mem_addr = '0;
    end

    // state, latched request and registered response; response fields clear as RESP is left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            q_size     <= '0;
            q_sgn      <= 1'b0;
            q_addr     <= '0;
            q_wdata    <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= next;
            if (accept) begin
                q_size   <= req_size;
                q_sgn    <= req_signed;
                q_addr   <= req_addr;
                q_wdata  <= req_wdata;
                resp_err <= err;
            end
            if (state == LD_WAIT)
                resp_rdata <= load_val;
            if (state == RESP) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a word memory model and directed load/store vectors
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = '0;
    logic        MemRead;
    logic        MemWrite;

    load_store_unit #(.MEM_WORDS(256), .CHECK_RANGE(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic [31:0] mem [256];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wd = '0;
    int          last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // memory with registered reads and no byte enables
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (MemWrite) begin
            mem[mem_addr[9:2]] <= mem_write_data;
            wr_cnt  <= wr_cnt + 1;
            last_wd <= mem_write_data;
        end
        if (MemRead) begin
            mem_read_data <= mem[mem_addr[9:2]];
            rd_cnt <= rd_cnt + 1;
        end
    end

    // monitor: every response pops one expectation
    always @(negedge clk) begin
        if (resp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("resp_cycle", cyc, e.due);
                chk("ready_in_resp", 32'(req_ready), 32'd0);
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee, input int lat,
                         input bit expect_resp);
        int t;
        t = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else begin
            last_acc = cyc;
            if (expect_resp) q.push_back('{er, ee, cyc + lat});
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_strobes"}, {30'd0, MemRead, MemWrite}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0;
        int acc[3];
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_reset", 32'(req_ready), 32'd1);

        issue(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0, 1, 1);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h11223344, 0, 2, 1);
        issue(0, 2'b00, 0, 32'h13, 32'h0, 32'h00000011, 0, 2, 1);
        issue(0, 2'b01, 0, 32'h12, 32'h0, 32'h00001122, 0, 2, 1);
        issue(0, 2'b01, 1, 32'h10, 32'h0, 32'h00003344, 0, 2, 1);
        drain();

        r0 = rd_cnt; w0 = wr_cnt;
        issue(1, 2'b00, 0, 32'h11, 32'h000000AA, 32'h0, 0, 2, 1);
        drain();
        chk("sb_reads", 32'(rd_cnt - r0), 32'd1);
        chk("sb_writes", 32'(wr_cnt - w0), 32'd1);
        chk("sb_merged", last_wd, 32'h1122AA44);
        issue(0, 2'b00, 1, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 2, 1);
        issue(0, 2'b00, 0, 32'h11, 32'h0, 32'h000000AA, 0, 2, 1);
        drain();

        r0 = rd_cnt; w0 = wr_cnt;
        issue(0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1, 1, 1);
        issue(1, 2'b01, 0, 32'h13, 32'h5555, 32'h0, 1, 1, 1);
        issue(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1, 1);
        issue(1, 2'b10, 0, 32'h400, 32'hDEADBEEF, 32'h0, 1, 1, 1);
        drain();
        chk("err_reads", 32'(rd_cnt - r0), 32'd0);
        chk("err_writes", 32'(wr_cnt - w0), 32'd0);

        w0 = wr_cnt;
        issue(1, 2'b01, 0, 32'h12, 32'h0000BEEF, 32'h0, 0, 2, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        chk("midreset_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_writes", 32'(wr_cnt - w0), 32'd0);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h1122AA44, 0, 2, 1);
        drain();

        @(negedge clk);
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int t;
            t = 0;
            req_write = 1'b0;
            req_size   = i == 0 ? 2'b10 : i == 1 ? 2'b00 : 2'b01;
            req_signed = i == 2;
            req_addr   = i == 0 ? 32'h10 : 32'h12;
            while (!req_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!req_ready) chk("b2b_accept_timeout", 32'd1, 32'd0);
            acc[i] = cyc;
            q.push_back('{i == 0 ? 32'h1122AA44 : i == 1 ? 32'h00000022 : 32'h00001122, 1'b0, cyc + 2});
            @(negedge clk);
            chk("b2b_ready_low", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        drain();
        chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'd3);
        chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'd3);

        issue(1, 2'b01, 0, 32'h12, 32'h1234BEEF, 32'h0, 0, 2, 1);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hBEEFAA44, 0, 2, 1);
        issue(0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFFBEEF, 0, 2, 1);
        drain();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
